// File: rtl/parc_mem_arb_pkg.sv
// Shared constants for the PARCv2 two-into-one memory arbiter: source IDs
// carried in the tag queue and the VC memory message widths.
package parc_mem_arb_pkg;

  // VC_MEM_REQ_MSG_SZ(32,32) and VC_MEM_RESP_MSG_SZ(32)
  localparam int unsigned MEM_REQ_MSG_SZ  = 67;
  localparam int unsigned MEM_RESP_MSG_SZ = 35;

  localparam logic PARC_MEM_ARB_SRC_IMEM = 1'b0;
  localparam logic PARC_MEM_ARB_SRC_DMEM = 1'b1;

  // Round-robin pick: on a tie the port that did not win last time goes next.
  function automatic logic rr_pick(logic last_grant, logic imem_val, logic dmem_val);
    if (imem_val && dmem_val) begin
      return ~last_grant;
    end else if (dmem_val) begin
      return PARC_MEM_ARB_SRC_DMEM;
    end else begin
      return PARC_MEM_ARB_SRC_IMEM;
    end
  endfunction

endpackage

// File: rtl/parc_mem_arb_tag_queue.sv
// In-order FIFO of 1-bit request source IDs. Enqueue is refused when full even
// if a dequeue happens in the same cycle (no bypass of the full condition).
module parc_mem_arb_tag_queue #(
  parameter int unsigned p_depth = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enq,
  input  logic                       enq_src,
  input  logic                       deq,
  output logic                       head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(p_depth):0]   count
);

  localparam int unsigned PtrW = $clog2(p_depth);

  logic [PtrW-1:0]    wr_ptr;
  logic [PtrW-1:0]    rd_ptr;
  logic [p_depth-1:0] mem;
  logic               do_enq;
  logic               do_deq;

  assign full   = (count == (PtrW + 1)'(p_depth));
  assign empty  = (count == '0);
  assign do_enq = enq && !full;
  assign do_deq = deq && !empty;
  assign head   = mem[rd_ptr];

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_enq) wr_ptr <= wr_ptr + 1'b1;
      if (do_deq) rd_ptr <= rd_ptr + 1'b1;
      case ({do_enq, do_deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Tag storage; contents are only observed when the queue is non-empty.
  always_ff @(posedge clk) begin
    if (do_enq) mem[wr_ptr] <= enq_src;
  end

endmodule

// File: rtl/parc_mem_arb.sv
// Round-robin arbiter merging the PARCv2 imem/dmem request ports onto one
// memory port, with in-order response steering via a source tag queue.
module parc_mem_arb
  import parc_mem_arb_pkg::*;
#(
  parameter int unsigned p_depth = 4
) (
  input  logic                         clk,
  input  logic                         reset,

  input  logic [MEM_REQ_MSG_SZ-1:0]    imemreq_msg,
  input  logic                         imemreq_val,
  output logic                         imemreq_rdy,
  output logic [MEM_RESP_MSG_SZ-1:0]   imemresp_msg,
  output logic                         imemresp_val,

  input  logic [MEM_REQ_MSG_SZ-1:0]    dmemreq_msg,
  input  logic                         dmemreq_val,
  output logic                         dmemreq_rdy,
  output logic [MEM_RESP_MSG_SZ-1:0]   dmemresp_msg,
  output logic                         dmemresp_val,

  output logic [MEM_REQ_MSG_SZ-1:0]    memreq_msg,
  output logic                         memreq_val,
  input  logic                         memreq_rdy,
  input  logic [MEM_RESP_MSG_SZ-1:0]   memresp_msg,
  input  logic                         memresp_val,

  output logic [$clog2(p_depth):0]     outstanding,
  output logic                         err_orphan
);

  logic last_grant;
  logic lock;
  logic lock_src;
  logic grant;
  logic grant_val;
  logic q_full;
  logic q_empty;
  logic q_head;
  logic req_fire;

  // Grant selection and the combinational request path.
  always_comb begin
    grant       = lock ? lock_src : rr_pick(last_grant, imemreq_val, dmemreq_val);
    grant_val   = grant ? dmemreq_val : imemreq_val;
    memreq_msg  = grant ? dmemreq_msg : imemreq_msg;
    memreq_val  = grant_val && !q_full && !reset;
    imemreq_rdy = (grant == PARC_MEM_ARB_SRC_IMEM) && memreq_rdy && !q_full && !reset;
    dmemreq_rdy = (grant == PARC_MEM_ARB_SRC_DMEM) && memreq_rdy && !q_full && !reset;
    req_fire    = memreq_val && memreq_rdy;
  end

  // Response fan-out, steered by the oldest outstanding tag.
  always_comb begin
    imemresp_msg = memresp_msg;
    dmemresp_msg = memresp_msg;
    imemresp_val = memresp_val && !q_empty && (q_head == PARC_MEM_ARB_SRC_IMEM) && !reset;
    dmemresp_val = memresp_val && !q_empty && (q_head == PARC_MEM_ARB_SRC_DMEM) && !reset;
  end

  // Round-robin history, stall lock and sticky orphan flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= PARC_MEM_ARB_SRC_IMEM;
      lock       <= 1'b0;
      lock_src   <= PARC_MEM_ARB_SRC_IMEM;
      err_orphan <= 1'b0;
    end else begin
      // Hold the grantee while a presented request is stalled so its msg stays put.
      lock     <= memreq_val && !memreq_rdy;
      lock_src <= grant;
      if (req_fire) last_grant <= grant;
      if (memresp_val && q_empty) err_orphan <= 1'b1;
    end
  end

  parc_mem_arb_tag_queue #(
    .p_depth (p_depth)
  ) u_tag_queue (
    .clk     (clk),
    .reset   (reset),
    .enq     (req_fire),
    .enq_src (grant),
    .deq     (memresp_val && !reset),
    .head    (q_head),
    .full    (q_full),
    .empty   (q_empty),
    .count   (outstanding)
  );

endmodule

// File: tb/tb_parc_mem_arb.sv
// Self-checking bench for parc_mem_arb: directed scenarios followed by random
// traffic, all checked against a queue-based behavioural model.
module tb_parc_mem_arb;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [66:0] imemreq_msg, dmemreq_msg, memreq_msg;
  logic        imemreq_val, imemreq_rdy, dmemreq_val, dmemreq_rdy;
  logic [34:0] imemresp_msg, dmemresp_msg, memresp_msg;
  logic        imemresp_val, dmemresp_val;
  logic        memreq_val, memreq_rdy, memresp_val;
  logic [2:0]  outstanding;
  logic        err_orphan;

  int tests = 0;
  int fails = 0;

  // Behavioural model state
  bit m_last;
  bit m_lock;
  bit m_lock_src;
  bit m_err;
  bit tagq[$];
  bit hs_i;
  bit hs_d;

  parc_mem_arb #(
    .p_depth (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .imemreq_msg  (imemreq_msg),
    .imemreq_val  (imemreq_val),
    .imemreq_rdy  (imemreq_rdy),
    .imemresp_msg (imemresp_msg),
    .imemresp_val (imemresp_val),
    .dmemreq_msg  (dmemreq_msg),
    .dmemreq_val  (dmemreq_val),
    .dmemreq_rdy  (dmemreq_rdy),
    .dmemresp_msg (dmemresp_msg),
    .dmemresp_val (dmemresp_val),
    .memreq_msg   (memreq_msg),
    .memreq_val   (memreq_val),
    .memreq_rdy   (memreq_rdy),
    .memresp_msg  (memresp_msg),
    .memresp_val  (memresp_val),
    .outstanding  (outstanding),
    .err_orphan   (err_orphan)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [66:0] obs, input logic [66:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [66:0] rand_req();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[66:0];
  endfunction

  function automatic logic [34:0] rand_resp();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[34:0];
  endfunction

  task automatic model_reset();
    m_last     = 1'b0;
    m_lock     = 1'b0;
    m_lock_src = 1'b0;
    m_err      = 1'b0;
    tagq.delete();
  endtask

  // Check one cycle's combinational outputs at the negedge, then advance the model.
  task automatic cycle();
    bit g, gv, full, mv, resp_ok;
    @(negedge clk);
    if (m_lock) g = m_lock_src;
    else if (imemreq_val && dmemreq_val) g = ~m_last;
    else g = dmemreq_val;
    gv      = g ? dmemreq_val : imemreq_val;
    full    = (tagq.size() == DEPTH);
    mv      = gv && !full;
    resp_ok = memresp_val && (tagq.size() > 0);
    chk("memreq_val", memreq_val, mv);
    chk("imemreq_rdy", imemreq_rdy, !g && memreq_rdy && !full);
    chk("dmemreq_rdy", dmemreq_rdy, g && memreq_rdy && !full);
    if (mv) chk("memreq_msg", memreq_msg, g ? dmemreq_msg : imemreq_msg);
    chk("imemresp_val", imemresp_val, resp_ok && (tagq[0] == 1'b0));
    chk("dmemresp_val", dmemresp_val, resp_ok && (tagq[0] == 1'b1));
    if (imemresp_val) chk("imemresp_msg", imemresp_msg, memresp_msg);
    if (dmemresp_val) chk("dmemresp_msg", dmemresp_msg, memresp_msg);
    chk("outstanding", outstanding, tagq.size());
    chk("err_orphan", err_orphan, m_err);
    hs_i = mv && memreq_rdy && !g;
    hs_d = mv && memreq_rdy && g;
    if (memresp_val && tagq.size() == 0) m_err = 1'b1;
    if (resp_ok) void'(tagq.pop_front());
    if (mv && memreq_rdy) begin
      tagq.push_back(g);
      m_last = g;
    end
    m_lock     = mv && !memreq_rdy;
    m_lock_src = g;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imemreq_val = 1'b0;
    dmemreq_val = 1'b0;
    memreq_rdy  = 1'b1;
    memresp_val = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [66:0] dmsg;
    reset       = 1'b1;
    imemreq_msg = '0;
    dmemreq_msg = '0;
    memresp_msg = '0;
    idle_inputs();
    imemreq_val = 1'b1;
    dmemreq_val = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // Reset values, with both ports requesting
    chk("rst_outstanding", outstanding, 0);
    chk("rst_err_orphan", err_orphan, 0);
    chk("rst_memreq_val", memreq_val, 0);
    chk("rst_imemreq_rdy", imemreq_rdy, 0);
    chk("rst_dmemreq_rdy", dmemreq_rdy, 0);
    do_reset();

    // Single imem read, response two cycles later
    imemreq_val = 1'b1;
    imemreq_msg = {1'b0, 32'h0000_1000, 2'b00, 32'h0};
    cycle();
    chk("single_out1", outstanding, 1);
    imemreq_val = 1'b0;
    cycle();
    memresp_val = 1'b1;
    memresp_msg = {1'b0, 2'b00, 32'hDEAD_BEEF};
    #1;
    chk("single_ival", imemresp_val, 1);
    chk("single_data", imemresp_msg, {1'b0, 2'b00, 32'hDEAD_BEEF});
    chk("single_dval", dmemresp_val, 0);
    cycle();
    memresp_val = 1'b0;
    chk("single_out0", outstanding, 0);

    // Tie right after reset: dmem first, then alternation
    do_reset();
    imemreq_val = 1'b1;
    dmemreq_val = 1'b1;
    imemreq_msg = rand_req();
    dmemreq_msg = rand_req();
    #1;
    chk("tie_first_dmem", dmemreq_rdy, 1);
    chk("tie_first_irdy", imemreq_rdy, 0);
    for (int k = 0; k < 4; k++) begin
      cycle();
      if (hs_i) imemreq_msg = rand_req();
      if (hs_d) dmemreq_msg = rand_req();
    end
    memresp_val = 1'b1;
    for (int k = 0; k < 4; k++) begin
      memresp_msg = rand_resp();
      #1;
      chk("tie_route_d", dmemresp_val, (k % 2 == 0));
      cycle();
    end
    idle_inputs();

    // Backpressure lock: dmem wins the tie, memory stalls for 3 cycles
    do_reset();
    imemreq_val = 1'b1;
    dmemreq_val = 1'b1;
    imemreq_msg = rand_req();
    dmsg        = rand_req();
    dmemreq_msg = dmsg;
    memreq_rdy  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("lock_msg", memreq_msg, dmsg);
      cycle();
    end
    memreq_rdy = 1'b1;
    #1;
    chk("lock_release_d", dmemreq_rdy, 1);
    cycle();
    idle_inputs();

    // Full queue: four accepted, fifth blocked even with a same-cycle response
    do_reset();
    imemreq_val = 1'b1;
    for (int k = 0; k < 4; k++) begin
      imemreq_msg = rand_req();
      cycle();
    end
    chk("full_out4", outstanding, 4);
    imemreq_msg = rand_req();
    cycle();
    memresp_val = 1'b1;
    #1;
    chk("full_no_issue", memreq_val, 0);
    cycle();
    memresp_val = 1'b0;
    #1;
    chk("full_issue_next", memreq_val, 1);
    cycle();
    idle_inputs();

    // Orphan response
    do_reset();
    memresp_val = 1'b1;
    #1;
    chk("orphan_ival", imemresp_val, 0);
    chk("orphan_dval", dmemresp_val, 0);
    cycle();
    memresp_val = 1'b0;
    cycle();
    chk("orphan_sticky", err_orphan, 1);
    do_reset();
    chk("orphan_cleared", err_orphan, 0);

    // Reset mid-flight clears outstanding asynchronously
    imemreq_val = 1'b1;
    for (int k = 0; k < 2; k++) begin
      imemreq_msg = rand_req();
      cycle();
    end
    imemreq_val = 1'b0;
    chk("midrst_out2", outstanding, 2);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_async", outstanding, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    memresp_val = 1'b1;
    cycle();
    memresp_val = 1'b0;
    chk("midrst_orphan", err_orphan, 1);
    do_reset();

    // Random traffic against the model
    hs_i = 1'b1;
    hs_d = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if (hs_i || !imemreq_val) begin
        imemreq_val = ($urandom_range(0, 3) != 0);
        imemreq_msg = rand_req();
      end
      if (hs_d || !dmemreq_val) begin
        dmemreq_val = ($urandom_range(0, 3) != 0);
        dmemreq_msg = rand_req();
      end
      memreq_rdy  = ($urandom_range(0, 3) != 0);
      memresp_val = (tagq.size() > 0) && ($urandom_range(0, 2) != 0);
      memresp_msg = rand_resp();
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/parc_mem_arb.md
# parc_mem_arb

Two-into-one memory request arbiter sitting directly downstream of the PARCv2 core's instruction and data memory ports. It merges the `imemreq`/`dmemreq` streams onto a single memory port and records the source of every accepted request in an in-order tag queue. It then steers each memory response back to the originating core port. This lets the pipelined core run against a single-ported test memory or cache.

## Interface
- `p_depth`, default 4: maximum outstanding requests, which is also the tag queue depth. Legal range is 2..16, power of two.
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high reset
- `imemreq_msg`  in  `VC_MEM_REQ_MSG_SZ(32,32)` (67)  instruction request from core
- `imemreq_val`  in  1  instruction request valid
- `imemreq_rdy`  out  1  instruction request accepted
- `imemresp_msg`  out  `VC_MEM_RESP_MSG_SZ(32)` (35)  instruction response
- `imemresp_val`  out  1  instruction response valid; the core always accepts it, so there is no rdy
- `dmemreq_msg`, `dmemreq_val`, `dmemreq_rdy`, `dmemresp_msg`, `dmemresp_val`: same widths and directions as the imem ports, for the data side
- `memreq_msg`  out  67  merged request to memory
- `memreq_val`  out  1  merged request valid
- `memreq_rdy`  in  1  memory accepts request
- `memresp_msg`  in  35  memory response; memory returns responses strictly in request order
- `memresp_val`  in  1  memory response valid
- `outstanding`  out  `$clog2(p_depth)+1`  number of in-flight requests
- `err_orphan`  out  1  sticky flag: a response arrived while the tag queue was empty

## Operation
- **Arbitration** is round-robin with a 1-bit `last_grant` register.
  - If both ports request, the port not equal to `last_grant` wins.
  - If only one port requests, it wins.
  - `last_grant` updates only on an accepted transfer (`memreq_val && memreq_rdy`).
- **Grant lock.** If `memreq_val && !memreq_rdy`, the current grantee is held in a `lock` register.
  - Next cycle the same port stays granted regardless of the other port.
  - This keeps the message stable; the core holds its `msg` while `val` is high without `rdy`.
  - `lock` clears on handshake.
- **Request path** (combinational):
  - `memreq_msg` is the grantee's msg.
  - `memreq_val` = grantee val AND queue not full.
  - Grantee `rdy` = `memreq_rdy` AND queue not full. The non-grantee `rdy` is 0.
- **Tag queue**: FIFO of 1-bit source IDs, `0`=imem and `1`=dmem.
  - Enqueue on request handshake.
  - Dequeue on `memresp_val` when the queue is non-empty.
- **Full rule.** When count == `p_depth`, no request is issued, even if a response dequeues in the same cycle. No enqueue-bypass of full.
- **Empty with response.** If `memresp_val` arrives and count == 0:
  - The response is dropped; neither `*resp_val` asserts.
  - `err_orphan` sets and stays set until reset.
- **Simultaneous enqueue and dequeue** when not full: count is unchanged and both pointers advance. Pointers wrap modulo `p_depth`.
- **Response steering** (combinational): `memresp_msg` fans out to both `imemresp_msg` and `dmemresp_msg`. `imemresp_val` = `memresp_val && !empty && head==0`; `dmemresp_val` similarly with `head==1`.

## Timing
- The request and response paths add zero cycles; both are pure combinational paths gated by registered state.
- Throughput: one request and one response per cycle.
- **Reset values:**
  - `last_grant`=imem, so dmem wins the first tie.
  - `lock` clear.
  - Queue empty; `outstanding`=0.
  - `err_orphan`=0.
  - All `rdy` and `val` outputs are 0 during reset. Msg outputs mirror their inputs.
- **Reset asserted mid-transaction**: all in-flight tags are discarded immediately (asynchronous). Responses arriving after reset deassertion with an empty queue raise `err_orphan`.

## Structure
- Shared header (`parc-MemArbConsts.v`) holds `PARC_MEM_ARB_SRC_IMEM`=1'b0, `PARC_MEM_ARB_SRC_DMEM`=1'b1, and the 67/35 message width defines, which are reused from `vc-MemReqMsg.v` and `vc-MemRespMsg.v`.
- One sub-module, `parc_mem_arb_tag_queue`: a parameterised 1-bit FIFO with enq/deq/full/empty/count and the no-bypass full rule.
- The arbiter, `lock` and `last_grant` logic stay in the top module.

## Test plan
- **Single imem read.** imem read addr 0x1000; memory responds 2 cycles later with data 0xDEADBEEF. Expect `imemresp_val`=1 with data 0xDEADBEEF, `dmemresp_val`=0, and `outstanding` going 0→1→0.
- **Tie at reset, then alternation.** Both ports request at the first cycle after reset. Expect dmem granted first, then imem, then alternating while both remain valid. Responses route D, I, D, I in order.
- **Backpressure lock.** `memreq_rdy`=0 for 3 cycles while dmem is granted and imem is also valid. Expect `memreq_msg` stable at the dmem msg and `imemreq_rdy`=0 throughout; dmem transfers on the first `rdy`=1 cycle.
- **Full queue.** With `p_depth`=4, issue 4 requests with no responses. Expect `memreq_val`=0 and both `rdy`=0 on the 5th request. In the same cycle that a response arrives, still no issue; the next cycle issues.
- **Orphan response.** `memresp_val`=1 with the queue empty. Expect no `*resp_val`, `err_orphan`=1 persisting until reset, and `err_orphan`=0 after reset.
- **Reset mid-flight.** Reset asserted with 2 outstanding requests. Expect `outstanding`=0 immediately, asynchronously, before the next clock edge.
